// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: Memory port modes, MIPS load/store op codes,
// FSM state encoding and the op decode / alignment helpers.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        BYTE      = 3'd1,
        HALFWORD  = 3'd2,
        WORD      = 3'd3,
        WORDLEFT  = 3'd4,
        WORDRIGHT = 3'd5
    } MemoryModes;

    // Codes 12..15 are undefined and decode to no memory access.
    typedef enum logic [3:0] {
        LB = 4'd0, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsuState_t;

    typedef struct packed {
        MemoryModes writeMode;
        MemoryModes readMode;
        logic       unsignedLoad;
        logic       isLoad;
    } opDecode_t;

    function automatic opDecode_t decodeOp(input lsu_op_t op);
        opDecode_t d;
        d = '{writeMode: NONE, readMode: NONE, unsignedLoad: 1'b0, isLoad: 1'b0};
        case (op)
            LB:      begin d.readMode = BYTE;      d.isLoad = 1'b1; end
            LBU:     begin d.readMode = BYTE;      d.isLoad = 1'b1; d.unsignedLoad = 1'b1; end
            LH:      begin d.readMode = HALFWORD;  d.isLoad = 1'b1; end
            LHU:     begin d.readMode = HALFWORD;  d.isLoad = 1'b1; d.unsignedLoad = 1'b1; end
            LW:      begin d.readMode = WORD;      d.isLoad = 1'b1; end
            LWL:     begin d.readMode = WORDLEFT;  d.isLoad = 1'b1; end
            LWR:     begin d.readMode = WORDRIGHT; d.isLoad = 1'b1; end
            SB:      d.writeMode = BYTE;
            SH:      d.writeMode = HALFWORD;
            SW:      d.writeMode = WORD;
            SWL:     d.writeMode = WORDLEFT;
            SWR:     d.writeMode = WORDRIGHT;
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic isAligned(input lsu_op_t op, input logic [1:0] low);
        logic ok;
        case (op)
            LH, LHU, SH: ok = ~low[0];
            LW, SW:      ok = (low == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_merge.sv
// Combines Memory's pre-shifted LWL/LWR read data with the old rt value;
// every other load passes straight through.
module lsu_merge
    import load_store_unit_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  k,
    input  logic [31:0] memData,
    input  logic [31:0] rtOld,
    output logic [31:0] result
);

    logic [31:0] mask;

    always_comb begin
        mask = 32'hFFFF_FFFF;
        case (op)
            LWL: begin
                case (k)
                    2'd0:    mask = 32'hFF00_0000;
                    2'd1:    mask = 32'hFFFF_0000;
                    2'd2:    mask = 32'hFFFF_FF00;
                    default: mask = 32'hFFFF_FFFF;
                endcase
            end
            LWR: begin
                case (k)
                    2'd0:    mask = 32'hFFFF_FFFF;
                    2'd1:    mask = 32'h00FF_FFFF;
                    2'd2:    mask = 32'h0000_FFFF;
                    default: mask = 32'h0000_00FF;
                endcase
            end
            default: mask = 32'hFFFF_FFFF;
        endcase
        result = (memData & mask) | (rtOld & ~mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: accepts one request, drives Memory for a single ACCESS cycle,
// then holds a registered response until writeback takes it.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_store_data,
    input  logic [DATA_W-1:0] req_rt_old,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_load_data,
    output logic              resp_is_load,
    output logic              resp_addr_error,
    output logic [ADDR_W-1:0] resp_bad_vaddr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output MemoryModes        mem_writeMode,
    output MemoryModes        mem_readMode,
    output logic              mem_unsignedLoad,
    input  logic [DATA_W-1:0] mem_dataOutput
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready,
    // a response transfers where resp_valid && resp_ready; resp_* hold until then.
    lsuState_t        state, stateNext;
    logic             accept, captureResp, releaseResp;
    lsu_op_t          reqOp, opQ;
    opDecode_t        dec;
    logic             reqErr, isLoadQ, errQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] rtOldQ, mergedData;

    assign reqOp  = lsu_op_t'(req_op);
    assign dec    = decodeOp(reqOp);
    assign reqErr = ~isAligned(reqOp, req_address[1:0]);
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (req_valid) stateNext = ACCESS;
            ACCESS:  stateNext = RESP;
            RESP:    if (resp_ready) stateNext = req_valid ? ACCESS : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE) || ((state == RESP) && resp_ready);
        captureResp = (state == ACCESS);
        releaseResp = (state == RESP) && resp_ready;
    end

    lsu_merge u_merge (
        .op      (opQ),
        .k       (addrQ[1:0]),
        .memData (mem_dataOutput),
        .rtOld   (rtOldQ),
        .result  (mergedData)
    );

    // mem_* are loaded only on an accept edge, so they are idle outside ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            opQ              <= LB;
            addrQ            <= '0;
            rtOldQ           <= '0;
            isLoadQ          <= 1'b0;
            errQ             <= 1'b0;
            mem_address      <= '0;
            mem_data         <= '0;
            mem_writeMode    <= NONE;
            mem_readMode     <= NONE;
            mem_unsignedLoad <= 1'b0;
        end else if (accept) begin
            opQ              <= reqOp;
            addrQ            <= req_address;
            rtOldQ           <= req_rt_old;
            isLoadQ          <= dec.isLoad;
            errQ             <= reqErr;
            mem_address      <= req_address;
            mem_data         <= (!reqErr && dec.writeMode != NONE) ? req_store_data : '0;
            mem_writeMode    <= reqErr ? NONE : dec.writeMode;
            mem_readMode     <= reqErr ? NONE : dec.readMode;
            mem_unsignedLoad <= !reqErr && dec.unsignedLoad;
        end else begin
            mem_address      <= '0;
            mem_data         <= '0;
            mem_writeMode    <= NONE;
            mem_readMode     <= NONE;
            mem_unsignedLoad <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (releaseResp && !captureResp)) begin
            resp_valid      <= 1'b0;
            resp_load_data  <= '0;
            resp_is_load    <= 1'b0;
            resp_addr_error <= 1'b0;
            resp_bad_vaddr  <= '0;
        end else if (captureResp) begin
            resp_valid      <= 1'b1;
            resp_load_data  <= (isLoadQ && !errQ) ? mergedData : '0;
            resp_is_load    <= isLoadQ;
            resp_addr_error <= errQ;
            resp_bad_vaddr  <= errQ ? addrQ : '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit driving a little-endian behavioural Memory model
// with combinational reads and writes committed on the rising edge.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_address, req_store_data, req_rt_old;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_load_data, resp_bad_vaddr;
    logic        resp_is_load, resp_addr_error;
    logic [31:0] mem_address, mem_data, mem_dataOutput;
    MemoryModes  mem_writeMode, mem_readMode;
    logic        mem_unsignedLoad;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_address(req_address), .req_store_data(req_store_data), .req_rt_old(req_rt_old),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_load_data(resp_load_data),
        .resp_is_load(resp_is_load), .resp_addr_error(resp_addr_error), .resp_bad_vaddr(resp_bad_vaddr),
        .mem_address(mem_address), .mem_data(mem_data), .mem_writeMode(mem_writeMode),
        .mem_readMode(mem_readMode), .mem_unsignedLoad(mem_unsignedLoad),
        .mem_dataOutput(mem_dataOutput)
    );

    // Memory model
    logic [31:0] memWords [0:16383];
    logic [13:0] wIdx;
    logic [31:0] oldWord, newWord, lmask, rmask;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    int          byteSh;

    always_comb begin
        wIdx           = mem_address[15:2];
        byteSh         = 8 * int'(mem_address[1:0]);
        oldWord        = memWords[wIdx];
        rdByte         = oldWord[byteSh +: 8];
        rdHalf         = mem_address[1] ? oldWord[31:16] : oldWord[15:0];
        lmask          = 32'hFFFF_FFFF >> (24 - byteSh);
        rmask          = 32'hFFFF_FFFF << byteSh;
        mem_dataOutput = 32'h0;
        newWord        = oldWord;
        case (mem_readMode)
            BYTE:      mem_dataOutput = mem_unsignedLoad ? {24'h0, rdByte} : {{24{rdByte[7]}}, rdByte};
            HALFWORD:  mem_dataOutput = mem_unsignedLoad ? {16'h0, rdHalf} : {{16{rdHalf[15]}}, rdHalf};
            WORD:      mem_dataOutput = oldWord;
            WORDLEFT:  mem_dataOutput = oldWord << (24 - byteSh);
            WORDRIGHT: mem_dataOutput = oldWord >> byteSh;
            default:   mem_dataOutput = 32'h0;
        endcase
        case (mem_writeMode)
            BYTE:      newWord[byteSh +: 8] = mem_data[7:0];
            HALFWORD:  if (mem_address[1]) newWord[31:16] = mem_data[15:0];
                       else newWord[15:0] = mem_data[15:0];
            WORD:      newWord = mem_data;
            WORDLEFT:  newWord = (oldWord & ~lmask) | ((mem_data >> (24 - byteSh)) & lmask);
            WORDRIGHT: newWord = (oldWord & ~rmask) | ((mem_data << byteSh) & rmask);
            default:   newWord = oldWord;
        endcase
    end

    always @(posedge clk) begin
        if (mem_writeMode != NONE) memWords[wIdx] <= newWord;
    end

    // Scoreboard
    int          checks = 0;
    int          failures = 0;
    logic [31:0] expQ[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] accAddr, accData, rData, rBad;
    MemoryModes  accWrite, accRead;
    logic        accUns, rErr, rIsLoad;
    int          rLat;

    // Drivers
    task automatic sendReq(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rt);
        int n;
        req_op = op; req_address = addr; req_store_data = sd; req_rt_old = rt;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) checkEq("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        accAddr = mem_address; accData = mem_data;
        accWrite = mem_writeMode; accRead = mem_readMode; accUns = mem_unsignedLoad;
    endtask

    task automatic waitResp();
        int n;
        n = 2;
        @(posedge clk);
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!resp_valid) checkEq("resp_timeout", 32'(resp_valid), 32'd1);
        rLat = n; rData = resp_load_data; rErr = resp_addr_error;
        rBad = resp_bad_vaddr; rIsLoad = resp_is_load;
    endtask

    task automatic doOp(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rt);
        sendReq(op, addr, sd, rt);
        waitResp();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, sd, rt, exp;
    } vec_t;
    vec_t vecs[$];

    task automatic addVec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rt, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.addr = addr; v.sd = sd; v.rt = rt; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_address = 32'd0;
        req_store_data = 32'd0; req_rt_old = 32'd0; resp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkEq("rst_resp_data", resp_load_data, 32'd0);
        checkEq("rst_bad_vaddr", resp_bad_vaddr, 32'd0);
        checkEq("rst_write_mode", 32'(mem_writeMode), 32'(NONE));
        checkEq("rst_read_mode", 32'(mem_readMode), 32'(NONE));
        checkEq("rst_mem_address", mem_address, 32'd0);
        checkEq("rst_mem_data", mem_data, 32'd0);
        checkEq("rst_unsigned", 32'(mem_unsignedLoad), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkEq("post_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Word store then load
        doOp(SW, 32'd65532, 32'h2234_5678, 32'd0);
        checkEq("sw_acc_write_mode", 32'(accWrite), 32'(WORD));
        checkEq("sw_acc_read_mode", 32'(accRead), 32'(NONE));
        checkEq("sw_acc_address", accAddr, 32'd65532);
        checkEq("sw_acc_data", accData, 32'h2234_5678);
        checkEq("sw_resp_data", rData, 32'd0);
        checkEq("sw_resp_is_load", 32'(rIsLoad), 32'd0);
        doOp(LW, 32'd65532, 32'd0, 32'd0);
        checkEq("lw_acc_read_mode", 32'(accRead), 32'(WORD));
        checkEq("lw_data", rData, 32'h2234_5678);
        checkEq("lw_addr_error", 32'(rErr), 32'd0);
        checkEq("lw_is_load", 32'(rIsLoad), 32'd1);
        checkEq("lw_latency", 32'(rLat), 32'd2);

        // Byte/halfword stores and partial loads
        addVec(SB,  32'd65528, 32'h1122_33D4, 32'd0, 32'h0000_0000);
        addVec(SB,  32'd65529, 32'h1122_33C3, 32'd0, 32'h0000_0000);
        addVec(SB,  32'd65530, 32'h1122_33B2, 32'd0, 32'h0000_0000);
        addVec(SB,  32'd65531, 32'h1122_33A1, 32'd0, 32'h0000_0000);
        addVec(LB,  32'd65531, 32'd0, 32'd0, 32'hFFFF_FFA1);
        addVec(LBU, 32'd65531, 32'd0, 32'd0, 32'h0000_00A1);
        addVec(LW,  32'd65528, 32'd0, 32'd0, 32'hA1B2_C3D4);
        addVec(LH,  32'd65530, 32'd0, 32'd0, 32'hFFFF_A1B2);
        addVec(LHU, 32'd65528, 32'd0, 32'd0, 32'h0000_C3D4);
        addVec(LWR, 32'd65529, 32'd0, 32'hEEEE_EEEE, 32'hEEA1_B2C3);
        addVec(LWL, 32'd65529, 32'd0, 32'hEEEE_EEEE, 32'hC3D4_EEEE);
        addVec(SH,  32'd65530, 32'h5555_BEEF, 32'd0, 32'h0000_0000);
        addVec(LW,  32'd65528, 32'd0, 32'd0, 32'hBEEF_C3D4);
        foreach (vecs[i]) begin
            expQ.push_back(vecs[i].exp);
            doOp(vecs[i].op, vecs[i].addr, vecs[i].sd, vecs[i].rt);
            checkEq($sformatf("vec%0d_data", i), rData, expQ.pop_front());
            checkEq($sformatf("vec%0d_err", i), 32'(rErr), 32'd0);
        end

        doOp(LBU, 32'd65531, 32'd0, 32'd0);
        checkEq("lbu_unsigned_flag", 32'(accUns), 32'd1);

        // Misaligned and undefined requests
        doOp(LH, 32'd65529, 32'd0, 32'd0);
        checkEq("lh_mis_error", 32'(rErr), 32'd1);
        checkEq("lh_mis_bad_vaddr", rBad, 32'd65529);
        checkEq("lh_mis_data", rData, 32'd0);
        checkEq("lh_mis_read_mode", 32'(accRead), 32'(NONE));
        checkEq("lh_mis_write_mode", 32'(accWrite), 32'(NONE));
        doOp(SW, 32'd65530, 32'hDEAD_BEEF, 32'd0);
        checkEq("sw_mis_error", 32'(rErr), 32'd1);
        checkEq("sw_mis_bad_vaddr", rBad, 32'd65530);
        checkEq("sw_mis_write_mode", 32'(accWrite), 32'(NONE));
        checkEq("sw_mis_latency", 32'(rLat), 32'd2);
        doOp(LW, 32'd65528, 32'd0, 32'd0);
        checkEq("lw_after_mis_sw", rData, 32'hBEEF_C3D4);
        doOp(4'hF, 32'd65528, 32'h1234_5678, 32'd0);
        checkEq("undef_error", 32'(rErr), 32'd0);
        checkEq("undef_is_load", 32'(rIsLoad), 32'd0);
        checkEq("undef_write_mode", 32'(accWrite), 32'(NONE));
        checkEq("undef_read_mode", 32'(accRead), 32'(NONE));

        // Unaligned word pieces
        doOp(SW, 32'd65528, 32'd0, 32'd0);
        doOp(SWL, 32'd65530, 32'h1234_5678, 32'd0);
        checkEq("swl_write_mode", 32'(accWrite), 32'(WORDLEFT));
        doOp(LWL, 32'd65530, 32'd0, 32'h0000_00EE);
        checkEq("lwl_merge", rData, 32'h1234_56EE);
        doOp(LW, 32'd65528, 32'd0, 32'd0);
        checkEq("lw_after_swl", rData, 32'h0012_3456);
        doOp(SWR, 32'd65529, 32'hAABB_CCDD, 32'd0);
        doOp(LW, 32'd65528, 32'd0, 32'd0);
        checkEq("lw_after_swr", rData, 32'hBBCC_DD56);

        // Back-to-back store then load with resp_ready held high
        sendReq(SW, 32'd65516, 32'hCAFE_F00D, 32'd0);
        req_op = LW; req_address = 32'd65516; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkEq("b2b_sw_resp_valid", 32'(resp_valid), 32'd1);
        checkEq("b2b_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkEq("b2b_lw_access", 32'(mem_readMode), 32'(WORD));
        checkEq("b2b_gap_resp_valid", 32'(resp_valid), 32'd0);
        waitResp();
        checkEq("b2b_lw_data", rData, 32'hCAFE_F00D);
        checkEq("b2b_lw_latency", 32'(rLat), 32'd2);
        @(posedge clk);
        #1;

        // Response back-pressure
        resp_ready = 1'b0;
        sendReq(LW, 32'd65532, 32'd0, 32'd0);
        waitResp();
        checkEq("hold_latency", 32'(rLat), 32'd2);
        req_op = SW; req_address = 32'd65532; req_store_data = 32'h0000_0055; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkEq($sformatf("hold%0d_resp_valid", i), 32'(resp_valid), 32'd1);
            checkEq($sformatf("hold%0d_data", i), resp_load_data, 32'h2234_5678);
            checkEq($sformatf("hold%0d_req_ready", i), 32'(req_ready), 32'd0);
            checkEq($sformatf("hold%0d_write_mode", i), 32'(mem_writeMode), 32'(NONE));
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        doOp(LW, 32'd65532, 32'd0, 32'd0);
        checkEq("hold_no_store", rData, 32'h2234_5678);

        // Reset during ACCESS of a store
        sendReq(SW, 32'd65520, 32'h1357_9BDF, 32'd0);
        checkEq("rst_acc_write_mode", 32'(accWrite), 32'(WORD));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkEq($sformatf("rst_acc%0d_resp_valid", i), 32'(resp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        doOp(LW, 32'd65520, 32'd0, 32'd0);
        checkEq("rst_acc_store_kept", rData, 32'h1357_9BDF);

        // Reset while a response is pending
        resp_ready = 1'b0;
        sendReq(LW, 32'd65532, 32'd0, 32'd0);
        waitResp();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        checkEq("rst_resp_discarded", 32'(resp_valid), 32'd0);
        checkEq("rst_resp_data_cleared", resp_load_data, 32'd0);
        checkEq("rst_resp_req_ready", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the data port of `Memory`. It accepts one MIPS load/store request at a time from the execute stage over a valid/ready handshake and checks alignment. It drives `Memory`'s `address`/`data`/`writeMode`/`readMode`/`unsignedLoad` for exactly one access cycle, merges LWL/LWR results with the old `rt` value, and returns a registered response to writeback.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; only 32 is supported

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_op`  in  4  `lsu_op_t`: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR
- `req_address`  in  32  effective byte address
- `req_store_data`  in  32  `rt` value for stores
- `req_rt_old`  in  32  current `rt` value, used for the LWL/LWR merge
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  response consumed when `resp_valid && resp_ready`
- `resp_load_data`  out  32  final register value for loads; 0 for stores and errors
- `resp_is_load`  out  1  response belongs to a load op
- `resp_addr_error`  out  1  misaligned access; no memory access was made
- `resp_bad_vaddr`  out  32  offending address when `resp_addr_error` is 1, else 0
- `mem_address`  out  32  to `Memory.address`
- `mem_data`  out  32  to `Memory.data`
- `mem_writeMode`  out  3  to `Memory.writeMode` (MemoryModes)
- `mem_readMode`  out  3  to `Memory.readMode` (MemoryModes)
- `mem_unsignedLoad`  out  1  to `Memory.unsignedLoad`
- `mem_dataOutput`  in  32  from `Memory.dataOutput`; combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On accept: latch op, address, store data and `rt_old`; compute alignment; go to ACCESS.
- Alignment rules:
  - LH/LHU/SH need `addr[0]`=0.
  - LW/SW need `addr[1:0]`=0.
  - Byte ops and LWL/LWR/SWL/SWR are always aligned.
- ACCESS, one cycle only. All `mem_*` outputs are registers loaded on the accept edge.
  - Store: `writeMode` is BYTE, HALFWORD, WORD, WORDLEFT or WORDRIGHT; `readMode`=NONE; `mem_data`=store data. `Memory` commits at the end of this cycle.
  - Load: `readMode` is the matching mode; `writeMode`=NONE. `unsignedLoad`=1 only for LBU/LHU. `Memory` performs sign/zero extension.
  - Misaligned request or undefined op code: both modes are NONE, so no memory effect.
  - At the end of the cycle: capture `mem_dataOutput` through the merge and go to RESP.
- Merge, with k = `addr[1:0]`:
  - LWL: mask = top k+1 bytes; result = (mem & mask) | (rt_old & ~mask).
  - LWR: mask = low 4−k bytes; same formula.
  - All other loads pass `mem_dataOutput` through unchanged.
- RESP:
  - `resp_valid`=1; outputs hold stable until `resp_ready`.
  - `req_ready` = `resp_ready`, so back-to-back requests are supported.
  - On `resp_ready`: go to ACCESS if a new request is accepted in the same cycle, else go to IDLE.
- `mem_*` outputs are NONE/0 in every cycle except ACCESS.

## Timing
- Request accepted at edge N → ACCESS in cycle N+1 → `resp_valid` from cycle N+2.
- Throughput: one access per 2 cycles when `resp_ready` is held at 1.
- Misaligned and undefined requests use the same 2-cycle latency.
- Reset values:
  - state=IDLE
  - `resp_valid`=0, `resp_*` data outputs=0
  - `mem_address`=0, `mem_data`=0
  - `mem_writeMode`=`mem_readMode`=NONE, `mem_unsignedLoad`=0
- `req_ready` is combinational from state and `resp_ready`; it is 1 in the first cycle after reset.
- Reset sampled at the end of an ACCESS cycle: a store still commits (Memory samples the same edge), no response is produced, and the FSM returns to IDLE.
- Reset while in RESP: the pending response is discarded.
- `resp_ready` held 0: RESP persists indefinitely, no new request is accepted, and `mem_*` stays NONE.
- A load issued immediately after a store to the same address sees the stored value, because the store commits before the load's ACCESS cycle.

## Structure
- Shared package additions:
  - `lsu_op_t` (4-bit enum).
  - `WORDRIGHT` added to `MemoryModes` if not already present.
  - Function mapping op → {writeMode, readMode, unsignedLoad, is_load}.
- Sub-module `lsu_merge`: combinational LWL/LWR mask generation and merge, taking inputs op, k, mem, rt_old.
- Top level: FSM plus registered request, `mem_*` and `resp_*` fields.

## Test plan
Bench instantiates `load_store_unit` connected to the real `Memory`.
- SW 0x22345678 @65532, then LW @65532 → `resp_load_data`=0x22345678, `resp_addr_error`=0, `resp_valid` 2 cycles after accept.
- SB 0xD4/0xC3/0xB2/0xA1 @65528..65531; LB @65531 → 0xFFFFFFA1; LBU @65531 → 0x000000A1; LW @65528 → 0xA1B2C3D4.
- Misaligned requests:
  - LH @65529 → `resp_addr_error`=1, `resp_bad_vaddr`=65529.
  - SW @65530 → error, and a later LW @65528 is unchanged.
  - `mem_writeMode` stays NONE throughout.
- SWL 0x12345678 @65530 on a zeroed word, then LWL @65530 with rt_old=0x000000EE → 0x123456EE; LW @65528 → 0x00123456.
- Back-to-back requests with `resp_ready`=1: SW then LW to the same address → load returns the stored value with no idle cycle between.
- Hold `resp_ready`=0 for 5 cycles → response stable and `req_ready`=0. Separately, assert `rst` during ACCESS of an SW → no `resp_valid`, but a subsequent LW returns the stored data.
